// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the slot after ptr
// sits at bit 0, pick the lowest set bit, then rotate the index back.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    localparam int W = SEL_W + 1;

    logic [W-1:0] start;
    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W-1:0] sum;
    logic [W-1:0] idx;

    assign start = ({1'b0, ptr} >= W'(N - 1)) ? '0 : {1'b0, ptr} + W'(1);
    assign rot   = N'({req, req} >> start);

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = W'(i);
        end
    end

    // start and off are both below N, so one conditional subtract wraps
    assign sum     = start + off;
    assign idx     = (sum >= W'(N)) ? sum - W'(N) : sum;
    assign any     = |req;
    assign gnt_idx = idx[SEL_W-1:0];
    assign grant   = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with fixed-select or round-robin
// arbitration and a registered output stage reporting the source channel.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_src,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;

    logic [NUM_IN-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_any;
    logic [NUM_IN-1:0] fix_grant;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any;
    logic              load;
    logic [DATA_W-1:0] data_sel;

    rr_arbiter #(
        .N     (NUM_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .grant   (rr_grant),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // an out-of-range sel matches no channel and so grants nothing
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) fix_grant[i] = in_valid[i];
        end
    end

    always_comb begin
        grant   = fix_grant;
        gnt_idx = sel;
        any     = |fix_grant;
        if (mode == MODE_RR) begin
            grant   = rr_grant;
            gnt_idx = rr_idx;
            any     = rr_any;
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) data_sel = in_data[i*DATA_W +: DATA_W];
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign in_ready = (load && !rst) ? grant : '0;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = any;
            if (any) begin
                out_data_d = data_sel;
                out_src_d  = gnt_idx;
                ptr_d      = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= SEL_W'(NUM_IN - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed scenarios plus a long
// random stream checked per channel for order, loss and duplication.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;

    logic            mode3;
    logic [1:0]      sel3;
    logic [2:0]      in_valid3;
    logic [3*DW-1:0] in_data3;
    logic [2:0]      in_ready3;
    logic            out_valid3;
    logic [DW-1:0]   out_data3;
    logic [1:0]      out_src3;
    logic            out_ready3;

    int n_cmp = 0;
    int n_err = 0;

    logic [SW+DW-1:0] exp_q[$];
    logic [DW-1:0]    chq[N][$];

    stream_mux_rr #(.NUM_IN(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.NUM_IN(3), .DATA_W(DW)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_src   (out_src3),
        .out_ready (out_ready3)
    );

    task automatic set_data(input logic [DW-1:0] d0, d1, d2, d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        in_valid = '0;
        in_valid3 = '0;
        out_ready = 1'b1;
        out_ready3 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        logic [SW+DW-1:0] e;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_in_ready: got %b want 0000", in_ready);
            end
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_out_valid: got %b want 0", out_valid);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_grant: got %b want 0001", in_ready);
        end
        exp_q.push_back({2'd0, 8'h11});
        @(negedge clk);
        in_valid = '0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_valid: got %b want 1", out_valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({out_src, out_data} !== e) begin
            n_err++;
            $display("FAIL reset_first_word: got %h want %h", {out_src, out_data}, e);
        end
    endtask

    task automatic test_fixed;
        logic [SW+DW-1:0] e;
        @(negedge clk);
        mode = 1'b0;
        sel = 2'd2;
        in_valid = '1;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL fixed_in_ready: got %b want 0100", in_ready);
        end
        exp_q.push_back({2'd2, 8'h33});
        @(negedge clk);
        in_valid = '0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fixed_out_valid: got %b want 1", out_valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({out_src, out_data} !== e) begin
            n_err++;
            $display("FAIL fixed_word: got %h want %h", {out_src, out_data}, e);
        end
    endtask

    task automatic test_rr;
        logic [SW+DW-1:0] e;
        logic [SW-1:0]    c;
        do_reset();
        mode = 1'b1;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        in_valid = '1;
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 8) in_valid = '0;
            end
            #1;
            if (k > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (out_valid !== 1'b1 || {out_src, out_data} !== e) begin
                    n_err++;
                    $display("FAIL rr_word_%0d: got v=%b %h want %h",
                             k, out_valid, {out_src, out_data}, e);
                end
            end
            if (k < 8) begin
                c = SW'(k % 4);
                n_cmp++;
                if (in_ready !== (4'b0001 << c)) begin
                    n_err++;
                    $display("FAIL rr_ready_%0d: got %b want %b",
                             k, in_ready, 4'b0001 << c);
                end
                exp_q.push_back({c, in_data[c*DW +: DW]});
            end
        end
    endtask

    task automatic test_sparse;
        logic [SW+DW-1:0] e;
        logic [SW-1:0]    c;
        do_reset();
        mode = 1'b0;
        sel = 2'd1;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        in_valid = 4'b0010;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL sparse_seed: got %b want 0010", in_ready);
        end
        exp_q.push_back({2'd1, 8'h22});
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            mode = 1'b1;
            in_valid = (j == 4) ? 4'b0000 : 4'b1010;
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {out_src, out_data} !== e) begin
                n_err++;
                $display("FAIL sparse_word_%0d: got v=%b %h want %h",
                         j, out_valid, {out_src, out_data}, e);
            end
            if (j < 4) begin
                c = (j % 2 == 0) ? 2'd3 : 2'd1;
                n_cmp++;
                if (in_ready !== (4'b0001 << c)) begin
                    n_err++;
                    $display("FAIL sparse_ready_%0d: got %b want %b",
                             j, in_ready, 4'b0001 << c);
                end
                exp_q.push_back({c, in_data[c*DW +: DW]});
            end
        end
        @(negedge clk);
        mode3 = 1'b0;
        sel3 = 2'd3;
        in_valid3 = 3'b111;
        in_data3 = {8'h77, 8'h66, 8'h55};
        out_ready3 = 1'b1;
        #1;
        n_cmp++;
        if (in_ready3 !== 3'b000) begin
            n_err++;
            $display("FAIL n3_sel3_ready: got %b want 000", in_ready3);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid3 !== 1'b0) begin
            n_err++;
            $display("FAIL n3_sel3_valid: got %b want 0", out_valid3);
        end
        sel3 = 2'd2;
        #1;
        n_cmp++;
        if (in_ready3 !== 3'b100) begin
            n_err++;
            $display("FAIL n3_sel2_ready: got %b want 100", in_ready3);
        end
        @(negedge clk);
        in_valid3 = '0;
        #1;
        n_cmp++;
        if ({out_valid3, out_src3, out_data3} !== {1'b1, 2'd2, 8'h77}) begin
            n_err++;
            $display("FAIL n3_sel2_word: got %h want %h",
                     {out_valid3, out_src3, out_data3}, {1'b1, 2'd2, 8'h77});
        end
    endtask

    task automatic test_backpressure;
        logic [SW+DW-1:0] e;
        do_reset();
        mode = 1'b0;
        sel = 2'd1;
        set_data(8'h00, 8'h5A, 8'h00, 8'h00);
        in_valid = 4'b0010;
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_load_ready: got %b want 0010", in_ready);
        end
        exp_q.push_back({2'd1, 8'h5A});
        @(negedge clk);
        set_data(8'h00, 8'h6B, 8'h00, 8'h00);
        sel = 2'd2;
        mode = 1'b1;
        exp_q.push_back({2'd1, 8'h6B});
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 8'h5A}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got %h want %h",
                         s, {out_valid, out_src, out_data}, {1'b1, 2'd1, 8'h5A});
            end
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_stall_ready_%0d: got %b want 0000", s, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 0010", in_ready);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_src, out_data} !== e) begin
            n_err++;
            $display("FAIL bp_release_word: got v=%b %h want %h",
                     out_valid, {out_src, out_data}, e);
        end
        @(negedge clk);
        in_valid = '0;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_src, out_data} !== e) begin
            n_err++;
            $display("FAIL bp_next_word: got v=%b %h want %h",
                     out_valid, {out_src, out_data}, e);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drained: got %b want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset;
        do_reset();
        mode = 1'b0;
        sel = 2'd2;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        in_valid = 4'b0100;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 8'h33}) begin
            n_err++;
            $display("FAIL mr_held: got %h want %h", {out_valid, out_data}, {1'b1, 8'h33});
        end
        rst = 1'b1;
        mode = 1'b1;
        in_valid = '1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL mr_ready_in_rst: got %b want 0000", in_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mr_discard: got %b want 0", out_valid);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mr_ptr_reset: got %b want 0001", in_ready);
        end
        @(negedge clk);
        in_valid = '0;
        #1;
        n_cmp++;
        if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 8'h11}) begin
            n_err++;
            $display("FAIL mr_first_word: got %h want %h",
                     {out_valid, out_src, out_data}, {1'b1, 2'd0, 8'h11});
        end
    endtask

    task automatic test_random;
        logic [N-1:0]  vld;
        logic [DW-1:0] cur[N];
        logic [DW-1:0] e;
        bit            done;
        do_reset();
        vld = '0;
        for (int c = 0; c < N; c++) cur[c] = '0;
        for (int cyc = 0; cyc < 10200; cyc++) begin
            @(negedge clk);
            if (cyc < 10000) begin
                if (cyc % 50 == 0) mode = 1'($urandom_range(0, 1));
                sel = SW'($urandom_range(0, 3));
                for (int c = 0; c < N; c++) begin
                    if (!vld[c] && $urandom_range(0, 3) != 0) begin
                        cur[c] = DW'($urandom);
                        vld[c] = 1'b1;
                        chq[c].push_back(cur[c]);
                    end
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mode = 1'b1;
                out_ready = 1'b1;
            end
            in_valid = vld;
            for (int c = 0; c < N; c++)
                in_data[c*DW +: DW] = vld[c] ? cur[c] : DW'($urandom);
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (chq[out_src].size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_dup: ch%0d got %h want none", out_src, out_data);
                end else begin
                    e = chq[out_src].pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL rnd_data: ch%0d got %h want %h", out_src, out_data, e);
                    end
                end
            end
            n_cmp++;
            if ((in_ready & ~vld) !== '0 || $countones(in_ready) > 1) begin
                n_err++;
                $display("FAIL rnd_ready: got %b want onehot within %b", in_ready, vld);
            end
            vld = vld & ~in_ready;
            done = (cyc >= 10000) && (vld == '0) && !out_valid;
            if (done) break;
        end
        in_valid = '0;
        for (int c = 0; c < N; c++) begin
            n_cmp++;
            if (chq[c].size() != 0) begin
                n_err++;
                $display("FAIL rnd_lost: ch%0d got %0d left want 0", c, chq[c].size());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b1;
        sel = '0;
        in_valid = '1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;
        mode3 = 1'b0;
        sel3 = '0;
        in_valid3 = '0;
        in_data3 = '0;
        out_ready3 = 1'b1;
        test_reset();
        test_fixed();
        test_rr();
        test_sparse();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
